// File: rtl/pipe_stage_buffer_if.sv
// Handshake and tap bus for pipe_stage_buffer. The master side drives the input
// entry and per-cycle controls; the slave side (the buffer) returns taps and counters.
interface pipe_stage_buffer_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    localparam int SW = $clog2(DEPTH + 1);

    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   in_ready;
    logic [SW-1:0]          hold_upto;
    logic [SW-1:0]          flush_upto;
    logic                   clr_cnt;
    logic [DEPTH*WIDTH-1:0] out_data;
    logic [DEPTH-1:0]       out_valid;
    logic [WIDTH-1:0]       last_data;
    logic                   last_valid;
    logic [SW-1:0]          occupancy;
    logic [CNT_W-1:0]       stall_cnt;
    logic [CNT_W-1:0]       kill_cnt;

    modport master (
        output in_valid, in_data, hold_upto, flush_upto, clr_cnt,
        input  in_ready, out_data, out_valid, last_data, last_valid,
               occupancy, stall_cnt, kill_cnt
    );

    modport slave (
        input  in_valid, in_data, hold_upto, flush_upto, clr_cnt,
        output in_ready, out_data, out_valid, last_data, last_valid,
               occupancy, stall_cnt, kill_cnt
    );
endinterface

// File: rtl/pipe_stage_buffer.sv
// DEPTH-stage pipeline buffer with per-stage valid, prefix stall (bubble insertion),
// prefix flush, and saturating stall/kill counters.
module pipe_stage_buffer #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    pipe_stage_buffer_if.slave bus
);
    localparam int SW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_p   [1:DEPTH];
    logic [DEPTH:1]   vld_p;
    logic [WIDTH-1:0] src_d    [0:DEPTH];
    logic [DEPTH:0]   src_v;
    logic [WIDTH-1:0] data_nxt [1:DEPTH];
    logic [DEPTH:1]   vld_nxt;
    logic [SW-1:0]    kill_now;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] kill_cnt_q;

    function automatic int clamp(input logic [SW-1:0] k);
        return (int'(k) > DEPTH) ? DEPTH : int'(k);
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                  input logic [SW-1:0]    b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W + 1)'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // Source of each stage: index 0 is the input entry, i is stage i.
    always_comb begin
        src_d[0] = bus.in_data;
        src_v[0] = bus.in_valid;
        for (int i = 1; i <= DEPTH; i++) begin
            src_d[i] = data_p[i];
            src_v[i] = vld_p[i];
        end
    end

    always_comb begin
        int h;
        int f;
        h        = clamp(bus.hold_upto);
        f        = clamp(bus.flush_upto);
        kill_now = '0;
        for (int i = 1; i <= DEPTH; i++) begin
            if (i <= h) begin
                data_nxt[i] = data_p[i];
                vld_nxt[i]  = vld_p[i];
            end else if (i == h + 1 && h > 0) begin
                data_nxt[i] = RESET_VAL;
                vld_nxt[i]  = 1'b0;
            end else begin
                data_nxt[i] = src_d[i-1];
                vld_nxt[i]  = src_v[i-1];
            end
        end
        // Flush overrides hold; every valid entry it wipes is a kill.
        for (int i = 1; i <= DEPTH; i++) begin
            if (i <= f) begin
                if (vld_nxt[i]) kill_now = kill_now + SW'(1);
                data_nxt[i] = RESET_VAL;
                vld_nxt[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i <= DEPTH; i++) data_p[i] <= RESET_VAL;
            vld_p       <= '0;
            stall_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            for (int i = 1; i <= DEPTH; i++) data_p[i] <= data_nxt[i];
            vld_p <= vld_nxt;
            if (bus.clr_cnt) begin
                stall_cnt_q <= '0;
                kill_cnt_q  <= '0;
            end else begin
                if (bus.hold_upto != '0) stall_cnt_q <= sat_add(stall_cnt_q, SW'(1));
                kill_cnt_q <= sat_add(kill_cnt_q, kill_now);
            end
        end
    end

    always_comb begin
        bus.out_data  = '0;
        bus.occupancy = '0;
        for (int i = 1; i <= DEPTH; i++) begin
            bus.out_data[i*WIDTH-1 -: WIDTH] = data_p[i];
            bus.occupancy = bus.occupancy + SW'(vld_p[i]);
        end
    end

    assign bus.in_ready   = (bus.hold_upto == '0);
    assign bus.out_valid  = vld_p;
    assign bus.last_data  = data_p[DEPTH];
    assign bus.last_valid = vld_p[DEPTH];
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.kill_cnt   = kill_cnt_q;
endmodule
